// File: rtl/conv3x3_stage_pkg.sv
// Shared definitions for the 3x3 convolution stage: AHB encodings, FSM states,
// accumulator width and the window tap-index helper.
package conv_pkg;

   localparam int ACC_W = 20;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, MAC, WR_ADDR, WR_DATA, NEXT, DONE
   } state_t;

   // Nine bytes, entry k = 3*kr + kc, so entry k lines up with weights[8k+7:8k].
   typedef logic [8:0][7:0] taps_t;

   function automatic logic [3:0] tapIndex(input logic [1:0] kr, input logic [1:0] kc);
      return {kr, 2'b00} - {2'b00, kr} + {2'b00, kc};
   endfunction

endpackage

// File: rtl/conv3x3_stage_if.sv
// AHB-lite master bus of the convolution stage, with master and slave views.
interface conv3x3_stage_if;
   logic [31:0] haddr;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic        hwrite;
   logic        sel;
   logic        hready_in;
   logic [31:0] hrdata;
   logic        hready_out;
   logic        hresp;

   modport master (
      output haddr, hburst, hprot, hsize, htrans, hwdata, hwrite, sel, hready_in,
      input  hrdata, hready_out, hresp
   );

   modport slave (
      input  haddr, hburst, hprot, hsize, htrans, hwdata, hwrite, sel, hready_in,
      output hrdata, hready_out, hresp
   );
endinterface

// File: rtl/conv3x3_stage_mac.sv
// Nine-cycle sequential multiply-accumulate with shift and clamp to one byte.
// Define CONV3X3_RELU_EN for ReLU clamping to [0,255]; otherwise signed [-128,127].
module conv3x3_mac
   import conv_pkg::*;
#(
   parameter int SHIFT = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic [3:0] i_tap,
   input  taps_t      i_weights,
   input  taps_t      i_window,
   output logic [7:0] o_byte
);

`ifdef CONV3X3_RELU_EN
   localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(0);
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(255);
`else
   localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-128);
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(127);
`endif

   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_weight;
   logic signed [ACC_W-1:0] w_pixel;
   logic signed [ACC_W-1:0] w_prod;
   logic signed [ACC_W-1:0] w_shift;

   // Pixels are unsigned, so they enter the product zero-extended.
   always_comb begin
      w_weight = {{(ACC_W-8){i_weights[i_tap][7]}}, i_weights[i_tap]};
      w_pixel  = {{(ACC_W-8){1'b0}}, i_window[i_tap]};
      w_prod   = w_weight * w_pixel;
      w_shift  = r_acc >>> SHIFT;
      o_byte   = (w_shift < Y_MIN) ? Y_MIN[7:0] :
                 (w_shift > Y_MAX) ? Y_MAX[7:0] : w_shift[7:0];
   end

   // Tap 0 restarts the sum, so each window starts from a clean accumulator.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= ((i_tap == 4'd0) ? '0 : r_acc) + w_prod;
      end
   end

endmodule

// File: rtl/conv3x3_stage.sv
// 3x3 convolution stage: reads the image over AHB with a sliding window,
// convolves through conv3x3_mac and writes the byte feature map back.
module conv3x3_stage
   import conv_pkg::*;
#(
   parameter int          IMG_W    = 84,
   parameter int          OUT_W    = 84 - 2,
   parameter logic [31:0] SRC_BASE = 32'h4001_0000,
   parameter logic [31:0] DST_BASE = 32'h4002_0000,
   parameter int          SHIFT    = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [71:0]        weights,
   output logic               finish,
   output logic [15:0]        o_errCnt,
   conv3x3_stage_if.master    bus
);

   localparam int CW = $clog2(IMG_W);

   state_t        r_state;
   logic          r_phase;
   logic [1:0]    r_kr, r_kc;
   logic [CW-1:0] r_row, r_col;
   logic [3:0]    r_tap;
   taps_t         r_weights, r_win;
   logic [31:0]   r_haddr, r_hwdata;
   logic [3:0]    r_hprot;
   logic [1:0]    r_htrans;
   logic          r_hwrite, r_sel, r_hreadyIn, r_finish;
   logic [15:0]   r_errCnt;

   logic [31:0]   w_rdAddr, w_wrAddr;
   logic [7:0]    w_laneByte, w_byte;
   logic          w_lastPixel;

   assign w_rdAddr    = SRC_BASE + (32'(r_row) + 32'(r_kr)) * 32'(IMG_W) + 32'(r_col) + 32'(r_kc);
   assign w_wrAddr    = DST_BASE + 32'(r_row) * 32'(OUT_W) + 32'(r_col);
   assign w_laneByte  = bus.hrdata[{r_haddr[1:0], 3'b000} +: 8];
   assign w_lastPixel = (r_row == CW'(OUT_W - 1)) && (r_col == CW'(OUT_W - 1));

   assign bus.haddr     = r_haddr;
   assign bus.hburst    = 3'b000;
   assign bus.hprot     = r_hprot;
   assign bus.hsize     = HSIZE_BYTE;
   assign bus.htrans    = r_htrans;
   assign bus.hwdata    = r_hwdata;
   assign bus.hwrite    = r_hwrite;
   assign bus.sel       = r_sel;
   assign bus.hready_in = r_hreadyIn;
   assign finish        = r_finish;
   assign o_errCnt      = r_errCnt;

   conv3x3_mac #(.SHIFT(SHIFT)) u_mac (
      .clk       (clk),
      .reset     (reset),
      .i_en      (r_state == MAC),
      .i_tap     (r_tap),
      .i_weights (r_weights),
      .i_window  (r_win),
      .o_byte    (w_byte)
   );

   // r_phase splits each address state into issue and retire cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_phase    <= 1'b0;
         r_kr       <= '0;
         r_kc       <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_tap      <= '0;
         r_weights  <= '0;
         r_win      <= '0;
         r_haddr    <= '0;
         r_hwdata   <= '0;
         r_hprot    <= '0;
         r_htrans   <= HTRANS_IDLE;
         r_hwrite   <= 1'b0;
         r_sel      <= 1'b0;
         r_hreadyIn <= 1'b0;
         r_finish   <= 1'b0;
         r_errCnt   <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_weights <= weights;
               r_row     <= '0;
               r_col     <= '0;
               r_kr      <= '0;
               r_kc      <= '0;
               r_phase   <= 1'b0;
               r_state   <= RD_ADDR;
            end
            RD_ADDR: if (!r_phase) begin
               if (bus.hready_out) begin
                  r_htrans   <= HTRANS_NONSEQ;
                  r_hwrite   <= 1'b0;
                  r_sel      <= 1'b1;
                  r_hprot    <= 4'd1;
                  r_hreadyIn <= 1'b1;
                  r_haddr    <= w_rdAddr;
                  r_phase    <= 1'b1;
               end
            end else begin
               r_htrans   <= HTRANS_IDLE;
               r_hreadyIn <= 1'b0;
               r_phase    <= 1'b0;
               r_state    <= RD_DATA;
            end
            RD_DATA: if (bus.hready_out) begin
               r_win[tapIndex(r_kr, r_kc)] <= w_laneByte;
               r_sel <= 1'b0;
               if (bus.hresp) r_errCnt <= r_errCnt + 16'd1;
               if (r_kr == 2'd2 && r_kc == 2'd2) begin
                  r_tap   <= '0;
                  r_state <= MAC;
               end else if (r_kc == 2'd2) begin
                  r_kr    <= r_kr + 2'd1;
                  r_kc    <= (r_col == '0) ? 2'd0 : 2'd2;
                  r_state <= RD_ADDR;
               end else begin
                  r_kc    <= r_kc + 2'd1;
                  r_state <= RD_ADDR;
               end
            end
            MAC: begin
               r_tap <= r_tap + 4'd1;
               if (r_tap == 4'd8) r_state <= WR_ADDR;
            end
            WR_ADDR: if (!r_phase) begin
               if (bus.hready_out && !bus.hresp) begin
                  r_htrans <= HTRANS_NONSEQ;
                  r_hwrite <= 1'b1;
                  r_hprot  <= 4'd9;
                  r_sel    <= 1'b1;
                  r_haddr  <= w_wrAddr;
                  r_hwdata <= {4{w_byte}};
                  r_phase  <= 1'b1;
               end
            end else begin
               r_htrans   <= HTRANS_IDLE;
               r_hreadyIn <= 1'b0;
               r_phase    <= 1'b0;
               r_state    <= WR_DATA;
            end
            WR_DATA: if (bus.hready_out) begin
               r_sel      <= 1'b0;
               r_hwrite   <= 1'b0;
               r_hwdata   <= '0;
               r_hprot    <= '0;
               r_hreadyIn <= 1'b1;
               if (bus.hresp) r_errCnt <= r_errCnt + 16'd1;
               r_state    <= NEXT;
            end
            // Moving right keeps two columns of the window; a new row refetches all nine.
            NEXT: begin
               r_kr <= '0;
               if (w_lastPixel) begin
                  r_haddr    <= '0;
                  r_hreadyIn <= 1'b0;
                  r_hprot    <= '0;
                  r_finish   <= 1'b1;
                  r_state    <= DONE;
               end else begin
                  if (r_col != CW'(OUT_W - 1)) begin
                     r_col <= r_col + CW'(1);
                     r_kc  <= 2'd2;
                     for (int kr = 0; kr < 3; kr++) begin
                        r_win[3*kr]     <= r_win[3*kr + 1];
                        r_win[3*kr + 1] <= r_win[3*kr + 2];
                     end
                  end else begin
                     r_col <= '0;
                     r_row <= r_row + CW'(1);
                     r_kc  <= 2'd0;
                  end
                  r_state <= RD_ADDR;
               end
            end
            DONE: if (!start) begin
               r_finish <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv3x3_stage.sv
// Scoreboard bench for conv3x3_stage on a small image, with an AHB slave model,
// random wait states and a behavioural convolution reference model.
module tb_conv3x3_stage;

   localparam int          IMG_W  = 8;
   localparam int          OUT_W  = IMG_W - 2;
   localparam logic [31:0] SRC    = 32'h4001_0000;
   localparam logic [31:0] DST    = 32'h4002_0000;
   localparam int          SHIFT  = 4;
   localparam int          LIMIT  = 5000;
   localparam int          BASE_CYCLES = 1 + OUT_W * (40 + (OUT_W - 1) * 22);

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [71:0] weights = '0;
   logic        finish;
   logic [15:0] errCnt;

   logic [7:0]  img [IMG_W*IMG_W];
   exp_t        expQ [$];
   int          checks = 0;
   int          passes = 0;
   int          waitTotal = 0;
   bit          useWaits = 1'b0;

   bit          pending = 1'b0;
   bit          pWrite;
   logic [31:0] pAddr;
   int          waitCnt;

   conv3x3_stage_if bus();

   conv3x3_stage #(
      .IMG_W(IMG_W), .OUT_W(OUT_W), .SRC_BASE(SRC), .DST_BASE(DST), .SHIFT(SHIFT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .weights  (weights),
      .finish   (finish),
      .o_errCnt (errCnt),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   function automatic logic [31:0] wordAt(input logic [31:0] addr);
      logic [31:0] w;
      int idx;
      w = '0;
      for (int l = 0; l < 4; l++) begin
         idx = int'((addr & 32'hFFFF_FFFC) - SRC) + l;
         if (idx >= 0 && idx < IMG_W*IMG_W) w[8*l +: 8] = img[idx];
      end
      return w;
   endfunction

   // Reference: direct 3x3 dot product, arithmetic shift and clamp per output pixel.
   task automatic buildExpected(input logic [71:0] w);
      int acc, y, lo, hi;
      logic signed [7:0] wk;
      exp_t e;
`ifdef CONV3X3_RELU_EN
      lo = 0;    hi = 255;
`else
      lo = -128; hi = 127;
`endif
      for (int r = 0; r < OUT_W; r++) begin
         for (int c = 0; c < OUT_W; c++) begin
            acc = 0;
            for (int kr = 0; kr < 3; kr++) begin
               for (int kc = 0; kc < 3; kc++) begin
                  wk  = w[8*(3*kr + kc) +: 8];
                  acc += int'(wk) * int'(img[(r + kr)*IMG_W + c + kc]);
               end
            end
            y = acc >>> SHIFT;
            if (y < lo) y = lo;
            if (y > hi) y = hi;
            e.addr = DST + 32'(r*OUT_W + c);
            e.data = 8'(y);
            expQ.push_back(e);
         end
      end
   endtask

   task automatic fillImage(input int mode, input logic [7:0] v);
      for (int i = 0; i < IMG_W; i++) begin
         for (int j = 0; j < IMG_W; j++) begin
            case (mode)
               0:       img[i*IMG_W + j] = v;
               1:       img[i*IMG_W + j] = 8'((i + j) % 256);
               default: img[i*IMG_W + j] = 8'($urandom);
            endcase
         end
      end
   endtask

   // Slave and monitor: a one-cycle address phase, then random wait states;
   // each completed write is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (!reset) begin
         pending        = 1'b0;
         bus.hready_out = 1'b1;
         bus.hresp      = 1'b0;
         bus.hrdata     = '0;
      end else if (pending) begin
         if (waitCnt == 0) begin
            bus.hready_out = 1'b1;
            if (pWrite) begin
               if (expQ.size() == 0) begin
                  checks++;
                  $display("[TB] FAIL unexpectedWrite: got address %h, expected no write", pAddr);
               end else begin
                  exp_t e;
                  e = expQ.pop_front();
                  checkOutput("wrAddr", pAddr, e.addr);
                  checkOutput("wrData", bus.hwdata, {4{e.data}});
               end
            end else begin
               bus.hrdata = wordAt(pAddr);
            end
            pending = 1'b0;
         end else begin
            bus.hready_out = 1'b0;
            waitCnt--;
            waitTotal++;
         end
      end else if (bus.htrans == 2'b10 && bus.sel) begin
         pending        = 1'b1;
         pAddr          = bus.haddr;
         pWrite         = bus.hwrite;
         waitCnt        = useWaits ? int'($urandom_range(0, 3)) : 0;
         bus.hready_out = 1'b1;
      end
   end

   function automatic logic [71:0] randWeights();
      return {8'($urandom), $urandom, $urandom};
   endfunction

   task automatic applyStimulus(input logic [71:0] w, input bit waits, input bit changeW);
      int cycles;
      useWaits  = waits;
      waitTotal = 0;
      buildExpected(w);
      @(negedge clk);
      weights = w;
      start   = 1'b1;
      cycles  = 0;
      do begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (changeW && cycles == 20) weights = randWeights();
      end while (!finish && cycles < LIMIT);
      checkOutput("frameCycles", 32'(cycles), 32'(BASE_CYCLES + waitTotal));
      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
      checkOutput("errCnt", {16'd0, errCnt}, 32'd0);
      expQ.delete();
      repeat (3) @(negedge clk);
      checkOutput("finishHeld", {31'd0, finish}, 32'd1);
      checkOutput("doneHtrans", {30'd0, bus.htrans}, 32'd0);
      checkOutput("doneHaddr", bus.haddr, 32'd0);
      start = 1'b0;
      @(negedge clk);
      checkOutput("finishCleared", {31'd0, finish}, 32'd0);
   endtask

   task automatic applyResetMidFrame(input logic [71:0] w, input int resetAt);
      useWaits = 1'b1;
      buildExpected(w);
      @(negedge clk);
      weights = w;
      start   = 1'b1;
      repeat (resetAt) @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      expQ.delete();
      checkOutput("rstFinish", {31'd0, finish}, 32'd0);
      checkOutput("rstHtrans", {30'd0, bus.htrans}, 32'd0);
      checkOutput("rstSel", {31'd0, bus.sel}, 32'd0);
      checkOutput("rstHaddr", bus.haddr, 32'd0);
      checkOutput("rstHwdata", bus.hwdata, 32'd0);
      checkOutput("rstHwrite", {31'd0, bus.hwrite}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("rstNoFinish", {31'd0, finish}, 32'd0);
      checkOutput("rstIdleBus", {30'd0, bus.htrans}, 32'd0);
   endtask

   initial begin
      logic [71:0] w;
      repeat (3) @(negedge clk);
      checkOutput("resetFinish", {31'd0, finish}, 32'd0);
      checkOutput("resetHtrans", {30'd0, bus.htrans}, 32'd0);
      checkOutput("resetSel", {31'd0, bus.sel}, 32'd0);
      checkOutput("resetHaddr", bus.haddr, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] identity kernel");
      fillImage(1, 8'd0);
      w = '0;
      w[39:32] = 8'(1 << SHIFT);
      applyStimulus(w, 1'b0, 1'b0);

      $display("[TB] random kernel, wait states, weights change mid-frame");
      fillImage(2, 8'd0);
      applyStimulus(randWeights(), 1'b1, 1'b1);

      $display("[TB] zero kernel");
      fillImage(2, 8'd0);
      applyStimulus('0, 1'b1, 1'b0);

      $display("[TB] positive saturation");
      fillImage(0, 8'd255);
      applyStimulus({9{8'h7f}}, 1'b0, 1'b0);

      $display("[TB] negative saturation");
      fillImage(0, 8'd255);
      applyStimulus({9{8'h80}}, 1'b1, 1'b0);

      $display("[TB] all -1 kernel");
      fillImage(0, 8'd200);
      applyStimulus({9{8'hff}}, 1'b0, 1'b0);

      $display("[TB] reset mid-frame then full frame");
      fillImage(2, 8'd0);
      applyResetMidFrame(randWeights(), 500);
      fillImage(2, 8'd0);
      applyStimulus(randWeights(), 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
